systolic_seq_ctrl: RTL and testbench

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl -- job sequencer for an NUM_ROWS x NUM_ROWS systolic array.
//
// One job: clear the PE accumulators, stream K operands through the skewed
// feeders until the wavefront drains (K+2N-2 cycles), then present the N
// result rows one at a time under a valid/ready handshake, then pulse done.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_start        job request, honoured only in IDLE with i_k_len != 0
//   i_k_len        inner dimension K, latched when start is accepted
//   o_busy         high outside IDLE
//   o_pe_clear     one-cycle accumulator clear (CLEAR state)
//   o_feed_valid   per-lane skewed operand valid, lane i live for i <= t < i+K
//   o_feed_cnt     feed cycle t (0 outside FEED); feeder i reads index t-i
//   o_res_valid    result row presented (READ state)
//   i_res_ready    consumer accepts the presented row
//   o_res_row      index of the presented result row
//   o_done         one-cycle completion pulse
//   i_abort        (SYSTOLIC_SEQ_CTRL_ABORT_EN only) cancel the running job
//   o_aborted      (SYSTOLIC_SEQ_CTRL_ABORT_EN only) one-cycle pulse in the
//                  IDLE cycle that follows an accepted abort
//
// Build option: define SYSTOLIC_SEQ_CTRL_ABORT_EN to add the abort ports.
module systolic_seq_ctrl #(
  parameter int NUM_ROWS = 16,
  parameter int CNT_W    = 8,
  parameter int T_W      = CNT_W + 6,
  localparam int RW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
  input  logic                i_abort,
  output logic                o_aborted,
`endif
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_k_len,
  output logic                o_busy,
  output logic                o_pe_clear,
  output logic [NUM_ROWS-1:0] o_feed_valid,
  output logic [T_W-1:0]      o_feed_cnt,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [RW-1:0]       o_res_row,
  output logic                o_done
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_READ, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_k;
  logic [T_W-1:0]   r_t;
  logic [RW-1:0]    r_row;
  logic [T_W-1:0]   w_k_ext;
  logic [T_W-1:0]   w_t_last;
  logic             w_abort;
  logic             w_in_job;
  logic             w_accept;

  assign w_k_ext  = T_W'(r_k);
  // Last feed cycle is K+2N-3: the final PE sees its last operand pair here.
  assign w_t_last = w_k_ext + T_W'(2 * NUM_ROWS - 3);
  assign w_accept = (r_state == S_IDLE) && i_start && (i_k_len != '0);
  // Abort only matters while a job is actually in flight.
  assign w_in_job = (r_state == S_CLEAR) || (r_state == S_FEED) || (r_state == S_READ);

`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
  assign w_abort = i_abort && w_in_job;
`else
  assign w_abort = 1'b0;
`endif

  // Next state and state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    o_busy      = (r_state != S_IDLE);
    o_pe_clear  = 1'b0;
    o_res_valid = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: begin
        o_pe_clear = 1'b1;
        w_next     = S_FEED;
      end
      S_FEED:  if (r_t == w_t_last) w_next = S_READ;
      S_READ: begin
        o_res_valid = 1'b1;
        if (i_res_ready && (r_row == RW'(NUM_ROWS - 1))) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_t     <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_k <= i_k_len;
      // t runs only while staying in FEED, so it is 0 on entry and in every other state.
      r_t <= ((r_state == S_FEED) && (w_next == S_FEED)) ? r_t + 1'b1 : '0;
      // Row index holds on stall, returns to 0 whenever READ is left.
      if (w_next == S_READ)
        r_row <= ((r_state == S_READ) && i_res_ready) ? r_row + 1'b1 : r_row;
      else
        r_row <= '0;
    end
  end

`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
  logic r_aborted;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_aborted <= 1'b0;
    else        r_aborted <= w_abort;
  end
  assign o_aborted = r_aborted;
`endif

  assign o_feed_cnt = (r_state == S_FEED) ? r_t : '0;
  assign o_res_row  = r_row;

  // Skewed lanes: lane i starts i cycles late and stays live for K cycles.
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_lane
    assign o_feed_valid[i] = (r_state == S_FEED) && (r_t >= T_W'(i)) &&
                             (r_t < T_W'(i) + w_k_ext);
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   k_len = '0;
  logic         busy, pe_clear, res_valid, done;
  logic         res_ready = 1'b1;
  logic [N-1:0] feed_valid;
  logic [13:0]  feed_cnt;
  logic [1:0]   res_row;
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
  logic         abort = 1'b0;
  logic         aborted;
`endif

  systolic_seq_ctrl #(.NUM_ROWS(N), .CNT_W(8), .T_W(14)) dut (
    .i_clk(clk),
    .i_rst(rst),
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
    .i_abort(abort),
    .o_aborted(aborted),
`endif
    .i_start(start),
    .i_k_len(k_len),
    .o_busy(busy),
    .o_pe_clear(pe_clear),
    .o_feed_valid(feed_valid),
    .o_feed_cnt(feed_cnt),
    .o_res_valid(res_valid),
    .i_res_ready(res_ready),
    .o_res_row(res_row),
    .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { int k; int feed; int lat; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int dones  = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [N-1:0] mask(input int k, input int t);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (t >= i) && (t < i + k);
    return m;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  exp_t cur;
  bit   active = 0;
  bit   in_read = 0;
  int   mt = 0, mrow = 0, cyc = 0, clr_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      active = 0;
    end else begin
      if (done) dones++;
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
      if (aborted) begin
        chk("aborted_while_active", int'(active), 1);
        active = 0;
      end
`endif
      if (pe_clear) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_clear: got pe_clear=1 expected 0 at cycle %0d", cyc);
        end else begin
          cur = q.pop_front();
          active = 1; in_read = 0; mt = 0; mrow = 0; clr_cyc = cyc;
        end
      end else if (active) begin
        if (res_valid) begin
          if (!in_read) begin
            chk("feed_length", mt, cur.feed);
            in_read = 1;
          end
          chk("res_row", int'(res_row), mrow);
          if (res_ready) mrow++;
        end else if (done) begin
          chk("rows_read", mrow, N);
          chk("job_latency", cyc - clr_cyc + 2, cur.lat);
          active = 0;
        end else if (busy) begin
          checks++;
          if (feed_cnt != 14'(mt) || feed_valid != mask(cur.k, mt)) begin
            errors++;
            $display("FAIL feed t=%0d: got cnt=%0d valid=%b expected cnt=%0d valid=%b",
                     mt, feed_cnt, feed_valid, mt, mask(cur.k, mt));
          end
          mt++;
        end else begin
          chk("busy_dropped", int'(busy), 1);
          active = 0;
        end
      end else begin
        chk("idle_outputs", int'({busy, feed_valid, feed_cnt, res_valid, done}), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int k, input int feed, input int lat);
    exp_t e;
    e.k = k; e.feed = feed; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic kick(input int k);
    @(posedge clk); #1 start = 1'b1; k_len = 8'(k);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic wait_feed(input int t);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (int'(feed_cnt) == t) return;
    end
    chk("feed_timeout", 0, 1);
  endtask

  int exp_dones;

  initial begin
    exp_dones = 4;
    #12;
    chk("reset_outputs", int'({busy, pe_clear, feed_valid, feed_cnt, res_valid, res_row, done}), 0);
    @(negedge clk); #1 rst = 1'b1;

    // k=3: 1+1+9+4+1 = 16; start and k_len changes mid-FEED ignored
    push(3, 9, 16);
    kick(3);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; k_len = 8'd7;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    #1 start = 1'b1; k_len = 8'd2;   // lands in the DONE cycle: ignored
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", int'(busy), 0);

    // k=0 is ignored
    kick(0);
    @(negedge clk);
    chk("k0_busy", int'(busy), 0);
    @(negedge clk);
    chk("k0_clear", int'(pe_clear), 0);

    // k=1: FEED 7, latency 14
    push(1, 7, 14);
    kick(1);
    wait_done();

    // k=3 with 3-cycle stall at row 2: latency 19
    push(3, 9, 19);
    kick(3);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (res_valid && res_row == 2'd1) break;
    end
    @(posedge clk); #1 res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_done();

    // reset mid-FEED at t=5, then restart on the first edge after release
    push(3, 9, 16);
    kick(3);
    wait_feed(5);
    #1 rst = 1'b0;
    #1 chk("async_reset_outputs",
           int'({busy, pe_clear, feed_valid, feed_cnt, res_valid, res_row, done}), 0);
    @(negedge clk);
    #1 rst = 1'b1; start = 1'b1; k_len = 8'd2;
    push(2, 8, 15);
    @(posedge clk); #1 start = 1'b0;
    wait_done();

`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
    push(3, 9, 16);
    kick(3);
    wait_feed(4);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_pulse", int'(aborted), 1);
    chk("abort_idle", int'({busy, feed_valid}), 0);
    @(negedge clk);
    chk("abort_single_pulse", int'(aborted), 0);
    // abort together with start in IDLE: start wins
    push(1, 7, 14);
    @(posedge clk); #1 start = 1'b1; abort = 1'b1; k_len = 8'd1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    wait_done();
    exp_dones = 5;
`endif

    repeat (3) @(negedge clk);
    chk("done_pulses", dones, exp_dones);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
